dac_update_sequencer: RTL
=========================

Name: dac_update_sequencer

Overview:
- Sequences updates of the on-chip DAC.
- Two digital requesters each present 8-bit codes: A is the host path from dedicated inputs, B is an on-chip pattern source.
- The block round-robin arbitrates A and B into a small code FIFO, then drains the FIFO to the DAC at a programmable update rate.
- Each load is followed by a fixed settle window, during which no new load is issued.

Parameters:
- DW, 8, DAC code width.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- DIV_W, 8, width of the rate divider.
- SETTLE, 3, settle cycles after each load; must be at least 1.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  sequencer enable.
- rate_div  in  DIV_W  update period minus 1, in clk cycles.
- a_valid  in  1  requester A has a code.
- a_data  in  DW  requester A code.
- a_ready  out  1  requester A code accepted this cycle.
- b_valid  in  1  requester B has a code.
- b_data  in  DW  requester B code.
- b_ready  out  1  requester B code accepted this cycle.
- dac_code  out  DW  registered code driven to the DAC.
- dac_load  out  1  one-cycle strobe: dac_code has changed.
- dac_busy  out  1  settle window is active.
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy.
- underrun  out  1  one-cycle pulse: an update tick found the FIFO empty.

Behaviour:
- Reset (async assert, removal synchronous to clk) sets:
  - FIFO empty, fifo_level=0.
  - dac_code=0, dac_load=0, dac_busy=0, underrun=0.
  - Divider count=0, state=IDLE, RR pointer=A.
- Arbitration (combinational ready):
  - grant_a = a_valid & (ptr==A | !b_valid).
  - grant_b = b_valid & (ptr==B | !a_valid).
  - x_ready = enable & grant_x & !full.
  - full is taken from the registered count. A push is therefore refused when full, even if a pop happens in the same cycle.
  - At most one push per cycle.
  - After a successful push, ptr moves to the other requester. With no push, ptr holds.
  - A valid request may be withdrawn without penalty.
- Divider:
  - When enable=1, cnt increments each cycle.
  - tick = (cnt==rate_div). On tick, cnt returns to 0 on the next edge.
  - rate_div=0 gives a tick every cycle.
  - When enable=0, cnt is held at 0 and no tick occurs.
  - If rate_div changes so that cnt>rate_div, cnt wraps through 2^DIV_W; no special handling.
- FSM IDLE -> SETTLE -> IDLE:
  - IDLE with tick and FIFO non-empty: on the edge, dac_code<=FIFO head, pop, dac_load<=1 for exactly one cycle, dac_busy<=1, settle_cnt<=SETTLE, go to SETTLE.
  - IDLE with tick and FIFO empty: underrun<=1 for one cycle; stay in IDLE; dac_code holds.
  - SETTLE: settle_cnt decrements each cycle. When settle_cnt==1, go to IDLE and dac_busy<=0. dac_busy is therefore high for exactly SETTLE cycles, starting in the same cycle as dac_load.
  - A tick arriving in SETTLE is discarded. It is not queued and does not count as an underrun.
- Latency:
  - A code pushed at edge N can load no earlier than edge N+1, when the FIFO is empty, in IDLE and ticking.
  - dac_code is visible one cycle after the tick cycle.
- Simultaneous push and pop with the FIFO neither full nor empty: level unchanged and order preserved.
- FIFO ordering is strict FIFO; pointers wrap modulo DEPTH.
- enable falling mid-operation:
  - Readies drop immediately.
  - An in-progress SETTLE completes normally.
  - FIFO contents are retained.
  - No further loads occur until enable returns.
- rst asserted mid-operation: all state clears immediately; dac_load and dac_busy fall without waiting for a clock.

Test Plan:
- Reset state: rst=1 with random inputs -> dac_code=0x00, dac_load=0, dac_busy=0, fifo_level=0, a_ready=b_ready=0. After release with enable=0 and a_valid=1 -> a_ready stays 0.
- Single load: enable=1, rate_div=0, push A=0x5A -> one-cycle dac_load with dac_code=0x5A; dac_busy high 3 cycles; next load no earlier than 4 cycles after the first.
- Round-robin: A and B both continuously valid (A=0x11.., B=0x22..), rate_div=255 -> FIFO fills A,B,A,B; fifo_level=4; both readies 0. Loads output 0x11,0x22,0x11,0x22, spaced 256 cycles apart.
- Rate: rate_div=9, FIFO kept non-empty, SETTLE=3 -> dac_load period exactly 10 cycles; no underrun.
- Underrun and discarded ticks: rate_div=1, a single code pushed -> one load, then an underrun pulse on the first IDLE tick with the FIFO empty; ticks during SETTLE produce no pulse; dac_code holds.
- Mid-operation: assert rst during SETTLE with fifo_level=3 -> outputs clear asynchronously and fifo_level=0. Separately, drop enable during SETTLE -> settle completes, fifo_level holds, no loads until re-enabled.

Source files
------------

// File: rtl/dac_update_sequencer_if.sv
// Requester handshakes, control inputs and DAC-side outputs of the DAC update sequencer.
// The sequencer itself connects through the slave modport; the driving side uses master.
interface dac_update_sequencer_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int DIV_W = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             enable;
  logic [DIV_W-1:0] rate_div;
  logic             a_valid;
  logic [DW-1:0]    a_data;
  logic             a_ready;
  logic             b_valid;
  logic [DW-1:0]    b_data;
  logic             b_ready;
  logic [DW-1:0]    dac_code;
  logic             dac_load;
  logic             dac_busy;
  logic [LW-1:0]    fifo_level;
  logic             underrun;

  modport master (
    output enable, rate_div, a_valid, a_data, b_valid, b_data,
    input  a_ready, b_ready, dac_code, dac_load, dac_busy, fifo_level, underrun
  );

  modport slave (
    input  enable, rate_div, a_valid, a_data, b_valid, b_data,
    output a_ready, b_ready, dac_code, dac_load, dac_busy, fifo_level, underrun
  );
endinterface

// File: rtl/dac_update_sequencer.sv
// Round-robin arbitrates two code requesters into a small FIFO and drains it to the DAC
// at a programmable rate, holding off further loads for a fixed settle window after each.
module dac_update_sequencer #(
  parameter int DW     = 8,
  parameter int DEPTH  = 4,
  parameter int DIV_W  = 8,
  parameter int SETTLE = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  dac_update_sequencer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(SETTLE + 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SETTLE = 1'b1;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;
  logic             r_rr_b;
  logic [DIV_W-1:0] r_cnt;
  logic [0:0]       r_state;
  logic [SW-1:0]    r_settle_cnt;
  logic [DW-1:0]    r_dac_code;
  logic             r_dac_load;
  logic             r_dac_busy;
  logic             r_underrun;

  logic             w_full;
  logic             w_empty;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_a_ready;
  logic             w_b_ready;
  logic             w_push;
  logic [DW-1:0]    w_push_data;
  logic             w_tick;
  logic             w_pop;

  assign w_full  = (r_count == LW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Readies are also held low while reset is asserted so nothing is accepted during it.
  assign w_grant_a = bus.a_valid & (~r_rr_b | ~bus.b_valid);
  assign w_grant_b = bus.b_valid & ( r_rr_b | ~bus.a_valid);
  assign w_a_ready = bus.enable & w_grant_a & ~w_full & ~rst;
  assign w_b_ready = bus.enable & w_grant_b & ~w_full & ~rst;
  assign w_push      = w_a_ready | w_b_ready;
  assign w_push_data = w_a_ready ? bus.a_data : bus.b_data;

  assign w_tick = bus.enable & (r_cnt == bus.rate_div);
  assign w_pop  = (r_state == ST_IDLE) & w_tick & ~w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rr_b   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr_b   <= w_a_ready;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A rate_div lowered below the running count simply lets r_cnt wrap around.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!bus.enable || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_dac_code   <= '0;
      r_dac_load   <= 1'b0;
      r_dac_busy   <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_dac_load <= 1'b0;
      r_underrun <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_tick && !w_empty) begin
            r_dac_code   <= r_mem[r_rd_ptr];
            r_dac_load   <= 1'b1;
            r_dac_busy   <= 1'b1;
            r_settle_cnt <= SW'(SETTLE);
            r_state      <= ST_SETTLE;
          end else if (w_tick) begin
            r_underrun <= 1'b1;
          end
        end
        default: begin
          // Ticks seen here are dropped on purpose: neither queued nor reported.
          if (r_settle_cnt == SW'(1)) begin
            r_dac_busy <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_settle_cnt <= r_settle_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.a_ready    = w_a_ready;
  assign bus.b_ready    = w_b_ready;
  assign bus.dac_code   = r_dac_code;
  assign bus.dac_load   = r_dac_load;
  assign bus.dac_busy   = r_dac_busy;
  assign bus.fifo_level = r_count;
  assign bus.underrun   = r_underrun;
endmodule
